// File: rtl/div_pkg.sv
// Shared types and constants for the divide execution unit.
// Optional DIV_EXC_FLAGS_EN adds divide-by-zero / overflow flag bits to the sideband.
package div_pkg;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    localparam int unsigned DIV_LATENCY  = 8;
    localparam logic [31:0] DIV_ALL_ONES = 32'hFFFF_FFFF;
    localparam logic [31:0] DIV_INT_MIN  = 32'h8000_0000;

    typedef struct packed {
        logic        valid;
        div_op_e     op;
        logic        neg_q;
        logic        neg_r;
        logic        special;
        logic [31:0] special_val;
        logic [4:0]  tag;
`ifdef DIV_EXC_FLAGS_EN
        logic        dz;
        logic        ovf;
`endif
    } div_sb_t;

endpackage

// File: rtl/div_exec_unit_if.sv
// Request/response bundle of the divide execution unit.
// DIV_EXC_FLAGS_EN adds the out_dz / out_ovf exception flags.
interface div_exec_unit_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_tag;
    logic        busy;
`ifdef DIV_EXC_FLAGS_EN
    logic        out_dz;
    logic        out_ovf;
`endif

    modport master (
        output in_valid, in_op, in_rs1, in_rs2, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag,
`ifdef DIV_EXC_FLAGS_EN
        input  out_dz, out_ovf,
`endif
        input  busy
    );

    modport slave (
        input  in_valid, in_op, in_rs1, in_rs2, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag,
`ifdef DIV_EXC_FLAGS_EN
        output out_dz, out_ovf,
`endif
        output busy
    );
endinterface

// File: rtl/div_exec_unit_divider.sv
// 8-stage unsigned pipelined restoring divider, 4 quotient bits resolved per stage.
// Divide-by-zero yields all-ones quotient and the dividend as remainder.
module div_exec_unit_divider
    import div_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    localparam int unsigned BITS_PER_STAGE = 32 / DIV_LATENCY;

    // acc holds {partial remainder, dividend bits not yet consumed / quotient bits}
    logic [63:0] acc_q [DIV_LATENCY];
    logic [31:0] dsr_q [DIV_LATENCY-1];

    function automatic logic [63:0] div_step(input logic [63:0] acc, input logic [31:0] dsr);
        logic [63:0] a;
        logic [32:0] hi;
        a = acc;
        for (int unsigned i = 0; i < BITS_PER_STAGE; i++) begin
            hi = a[63:31];
            a  = {a[62:0], 1'b0};
            if (hi >= {1'b0, dsr}) begin
                hi   = hi - {1'b0, dsr};
                a[0] = 1'b1;
            end
            a[63:32] = hi[31:0];
        end
        return a;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned s = 0; s < DIV_LATENCY; s++) acc_q[s] <= '0;
            for (int unsigned s = 0; s < DIV_LATENCY - 1; s++) dsr_q[s] <= '0;
        end else if (!stall) begin
            acc_q[0] <= div_step({32'h0, dividend}, divisor);
            dsr_q[0] <= divisor;
            for (int unsigned s = 1; s < DIV_LATENCY; s++) acc_q[s] <= div_step(acc_q[s-1], dsr_q[s-1]);
            for (int unsigned s = 1; s < DIV_LATENCY - 1; s++) dsr_q[s] <= dsr_q[s-1];
        end
    end

    assign quotient  = acc_q[DIV_LATENCY-1][31:0];
    assign remainder = acc_q[DIV_LATENCY-1][63:32];

endmodule

// File: rtl/div_exec_unit.sv
// RISC-V M-extension divide unit: sign fixup and special cases around the unsigned divider.
// Defining DIV_EXC_FLAGS_EN adds out_dz / out_ovf result flags.
module div_exec_unit
    import div_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    div_exec_unit_if.slave io
);

    logic        advance;
    logic        stall;
    logic        is_signed;
    logic [31:0] dvd;
    logic [31:0] dsr;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic [31:0] base;
    logic [31:0] result;
    logic        any_valid;
    div_sb_t     sb_in;
    div_sb_t     sb_out;
    div_sb_t     sb_q [DIV_LATENCY];

    assign sb_out      = sb_q[DIV_LATENCY-1];
    assign advance     = !(sb_out.valid && !io.out_ready);
    assign stall       = !advance;
    assign io.in_ready = advance || rst;

    always_comb begin
        is_signed         = !io.in_op[0];
        sb_in             = '0;
        sb_in.valid       = io.in_valid && advance;
        sb_in.op          = div_op_e'(io.in_op);
        sb_in.tag         = io.in_tag;
        sb_in.neg_q       = is_signed && (io.in_rs1[31] ^ io.in_rs2[31]);
        sb_in.neg_r       = is_signed && io.in_rs1[31];
        dvd               = (is_signed && io.in_rs1[31]) ? -io.in_rs1 : io.in_rs1;
        dsr               = (is_signed && io.in_rs2[31]) ? -io.in_rs2 : io.in_rs2;
        if (io.in_rs2 == '0) begin
            sb_in.special     = 1'b1;
            sb_in.special_val = io.in_op[1] ? io.in_rs1 : DIV_ALL_ONES;
`ifdef DIV_EXC_FLAGS_EN
            sb_in.dz          = 1'b1;
`endif
        end else if (is_signed && io.in_rs1 == DIV_INT_MIN && io.in_rs2 == DIV_ALL_ONES) begin
            sb_in.special     = 1'b1;
            sb_in.special_val = io.in_op[1] ? '0 : DIV_INT_MIN;
`ifdef DIV_EXC_FLAGS_EN
            sb_in.ovf         = 1'b1;
`endif
        end
    end

    div_exec_unit_divider u_divider (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .dividend  (dvd),
        .divisor   (dsr),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned s = 0; s < DIV_LATENCY; s++) sb_q[s] <= '0;
        end else if (advance) begin
            sb_q[0] <= sb_in;
            for (int unsigned s = 1; s < DIV_LATENCY; s++) sb_q[s] <= sb_q[s-1];
        end
    end

    always_comb begin
        any_valid = 1'b0;
        for (int unsigned s = 0; s < DIV_LATENCY; s++) any_valid = any_valid | sb_q[s].valid;
    end

    always_comb begin
        base   = sb_out.op[1] ? remainder : quotient;
        result = base;
        if (sb_out.special)
            result = sb_out.special_val;
        else if (sb_out.op[1] ? sb_out.neg_r : sb_out.neg_q)
            result = -base;
    end

    // Outputs are gated so they read idle during the reset cycle itself, before the registers clear.
    assign io.out_valid  = sb_out.valid && !rst;
    assign io.out_result = rst ? '0 : result;
    assign io.out_tag    = rst ? '0 : sb_out.tag;
    assign io.busy       = any_valid && !rst;
`ifdef DIV_EXC_FLAGS_EN
    assign io.out_dz     = sb_out.dz && !rst;
    assign io.out_ovf    = sb_out.ovf && !rst;
`endif

endmodule

// File: tb/tb_div_exec_unit.sv
// Scoreboard bench for div_exec_unit: directed corner cases, stall, mid-flight reset, random traffic.
// Checks out_dz / out_ovf as well when DIV_EXC_FLAGS_EN is defined.
module tb_div_exec_unit;
    import div_pkg::*;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        logic        dz;
        logic        ovf;
        int unsigned cyc;
        bit          chk_lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div_exec_unit_if io ();
    div_exec_unit dut (.clk(clk), .rst(rst), .io(io));

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          checks = 0;
    int          errors = 0;
    int          rdy_mode = 0;
    int unsigned stall_cnt = 0;
    exp_t        sb_q[$];
    logic        held = 1'b0;
    logic [31:0] held_res;
    logic [4:0]  held_tag;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference: RISC-V M semantics straight from signed/unsigned integer arithmetic.
    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   sa;
        int   sbv;
        e = '{res: '0, tag: '0, dz: 1'b0, ovf: 1'b0, cyc: 0, chk_lat: 1'b0};
        sa  = a;
        sbv = b;
        if (b == 0) begin
            e.dz  = 1'b1;
            e.res = op[1] ? a : 32'hFFFF_FFFF;
        end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.ovf = 1'b1;
            e.res = op[1] ? 32'h0 : 32'h8000_0000;
        end else begin
            case (op)
                2'b00:   e.res = sa / sbv;
                2'b01:   e.res = a / b;
                2'b10:   e.res = sa % sbv;
                default: e.res = a % b;
            endcase
        end
        return e;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input bit chk_lat);
        exp_t e;
        int   waited;
        bit   ok;
        io.in_valid = 1'b1;
        io.in_op    = op;
        io.in_rs1   = a;
        io.in_rs2   = b;
        io.in_tag   = tag;
        waited      = 0;
        ok          = 1'b0;
        while (!ok && waited < 50) begin
            @(negedge clk);
            if (io.in_ready) ok = 1'b1;
            else begin
                waited++;
                @(posedge clk);
                #1;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: in_ready stuck low, got 0 expected 1 at cycle %0d", cyc);
        end else begin
            e         = model(op, a, b);
            e.tag     = tag;
            e.cyc     = cyc;
            e.chk_lat = chk_lat;
            sb_q.push_back(e);
            @(posedge clk);
            #1;
        end
        io.in_valid = 1'b0;
    endtask

    task automatic reset_checks(input string name);
        check({name, "_out_valid"}, io.out_valid, 32'd0);
        check({name, "_in_ready"}, io.in_ready, 32'd1);
        check({name, "_busy"}, io.busy, 32'd0);
        check({name, "_out_result"}, io.out_result, 32'd0);
        check({name, "_out_tag"}, io.out_tag, 32'd0);
`ifdef DIV_EXC_FLAGS_EN
        check({name, "_out_dz"}, io.out_dz, 32'd0);
        check({name, "_out_ovf"}, io.out_ovf, 32'd0);
`endif
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return $urandom_range(0, 20);
            4:       return -$urandom_range(1, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        io.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: io.out_ready = 1'b1;
                1: begin
                    if (io.out_valid && stall_cnt < 3) begin
                        io.out_ready = 1'b0;
                        stall_cnt++;
                    end else io.out_ready = 1'b1;
                end
                default: io.out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: pops the scoreboard on every accepted result, checks hold-stability under back-pressure.
    always @(negedge clk) begin
        exp_t e;
        if (rst) held = 1'b0;
        else begin
            if (held) begin
                check("hold_valid", io.out_valid, 32'd1);
                check("hold_result", io.out_result, held_res);
                check("hold_tag", io.out_tag, held_tag);
            end
            if (io.out_valid && !io.out_ready) check("stall_in_ready", io.in_ready, 32'd0);
            if (io.out_valid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got result 0x%08h tag %0d, expected no output", io.out_result, io.out_tag);
                end else if (io.out_ready) begin
                    e = sb_q.pop_front();
                    check("result", io.out_result, e.res);
                    check("tag", io.out_tag, e.tag);
`ifdef DIV_EXC_FLAGS_EN
                    check("dz", io.out_dz, e.dz);
                    check("ovf", io.out_ovf, e.ovf);
`endif
                    if (e.chk_lat) check("latency", cyc - e.cyc, 32'd8);
                end
            end
            held     = io.out_valid && !io.out_ready;
            held_res = io.out_result;
            held_tag = io.out_tag;
        end
    end

    initial begin
        int waited;
        rst         = 1'b1;
        io.in_valid = 1'b0;
        io.in_op    = '0;
        io.in_rs1   = '0;
        io.in_rs2   = '0;
        io.in_tag   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_checks("init");
        @(posedge clk);
        #1 rst = 1'b0;

        issue(OP_DIVU, 32'd100, 32'd7, 5'd3, 1'b1);
        issue(OP_REMU, 32'd100, 32'd7, 5'd4, 1'b1);
        idle(12);

        issue(OP_DIV,  -32'sd7, 32'd2, 5'd10, 1'b1);
        issue(OP_REM,  -32'sd7, 32'd2, 5'd11, 1'b1);
        issue(OP_DIV,  32'd7, -32'sd2, 5'd12, 1'b1);
        issue(OP_REM,  32'd7, -32'sd2, 5'd13, 1'b1);
        issue(OP_DIV,  32'd5, 32'd0, 5'd14, 1'b1);
        issue(OP_REMU, 32'd5, 32'd0, 5'd15, 1'b1);
        issue(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 1'b1);
        issue(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 1'b1);
        issue(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 1'b1);
        issue(OP_REM,  -32'sd9, 32'd0, 5'd19, 1'b1);
        idle(12);

        stall_cnt = 0;
        rdy_mode  = 1;
        for (int i = 0; i < 10; i++)
            issue(2'($urandom_range(0, 3)), $urandom, $urandom_range(1, 1000), 5'(i), 1'b0);
        idle(20);
        rdy_mode = 0;

        for (int i = 0; i < 4; i++) issue(OP_DIVU, 32'd1000 + i, 32'd3, 5'(20 + i), 1'b0);
        rst = 1'b1;
        sb_q.delete();
        @(negedge clk);
        reset_checks("midrst");
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_busy", io.busy, 32'd0);
        @(posedge clk);
        #1;
        issue(OP_DIVU, 32'd1000, 32'd10, 5'd30, 1'b1);
        idle(12);

        rdy_mode = 2;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 4) == 0) idle(1);
            else issue(2'($urandom_range(0, 3)), rand_operand(), rand_operand(), 5'($urandom), 1'b0);
        end
        rdy_mode = 0;

        waited = 0;
        while ((sb_q.size() != 0 || io.busy) && waited < 100) begin
            idle(1);
            waited++;
        end
        check("drain_empty", sb_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_exec_unit.md
DIV_EXEC_UNIT -- requirements
Module: div_exec_unit

Interface
- REQ-001 clk  input  1  clock; all state updates on rising edge.
- REQ-002 rst  input  1  reset, synchronous, active-high.
- REQ-003 in_valid  input  1  request present.
- REQ-004 in_ready  output  1  request accepted this cycle when in_valid && in_ready.
- REQ-005 in_op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- REQ-006 in_rs1  input  32  dividend.
- REQ-007 in_rs2  input  32  divisor.
- REQ-008 in_tag  input  5  destination tag, returned unchanged with the result.
- REQ-009 out_valid  output  1  result present.
- REQ-010 out_ready  input  1  consumer accepts result when out_valid && out_ready.
- REQ-011 out_result  output  32  RISC-V M-extension result.
- REQ-012 out_tag  output  5  tag of the result.
- REQ-013 busy  output  1  high while any valid op is in flight.

Function
- REQ-014 The datapath SHALL be the team's 8-stage unsigned pipelined divider, with the divider's stall and rst driven by this block.
- REQ-015 Advance SHALL be !(stage-8 valid && !out_ready); divider stall = !advance; in_ready = advance.
- REQ-016 A sideband pipeline of 8 registers {valid, op, neg_q, neg_r, special, special_val, tag} SHALL shift in lockstep with the divider only when advance=1.
- REQ-017 Unstalled latency SHALL be exactly 8 cycles from acceptance to out_valid; throughput 1 op/cycle; results in issue order.
- REQ-018 A cycle with advance=1 and no acceptance SHALL insert valid=0 into stage 1.
- REQ-019 Signed ops (DIV, REM) SHALL feed the divider abs(rs1) and abs(rs2); unsigned ops SHALL feed raw operands.
- REQ-020 neg_q SHALL equal signed && rs1[31]^rs2[31]; neg_r SHALL equal signed && rs1[31].
- REQ-021 Output SHALL be quotient for DIV/DIVU, remainder for REM/REMU, two's-complement negated when the matching neg flag is set.
- REQ-022 Divide-by-zero, decided at issue: DIV/DIVU SHALL return 0xFFFFFFFF; REM/REMU SHALL return rs1.
- REQ-023 Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF): DIV SHALL return 0x80000000; REM SHALL return 0.
- REQ-024 Special-case results SHALL override the divider result at stage 8.
- REQ-025 out_valid, out_result and out_tag SHALL be combinational from stage-8 registers and SHALL stay stable while out_valid && !out_ready.
- REQ-026 Simultaneous output accept and input accept SHALL both occur in the same cycle with no bubble.

Reset
- REQ-027 While rst=1, all sideband valid bits SHALL clear, and divider stage registers SHALL clear.
- REQ-028 While rst=1, out_valid=0, out_result=0, out_tag=0, busy=0 and in_ready=1.
- REQ-029 Ops in flight when rst asserts SHALL be discarded and never produce out_valid.

Configuration
- REQ-030 With DIV_EXC_FLAGS_EN defined, the block SHALL add outputs out_dz (1) and out_ovf (1) that flag REQ-022 and REQ-023 cases, aligned with out_valid and reset to 0.
- REQ-031 Without DIV_EXC_FLAGS_EN, these ports and their sideband bits SHALL be absent; all other behaviour is identical.

Structure
- REQ-032 Shared package div_pkg SHALL hold the op encoding enum, DIV_LATENCY=8, and constants DIV_ALL_ONES=0xFFFFFFFF and DIV_INT_MIN=0x80000000.
- REQ-033 The only sub-module SHALL be the unsigned pipelined divider; sign fixup and sideband logic SHALL stay in div_exec_unit.

Verification
- REQ-034 DIVU 100/7 then REMU 100/7 back-to-back, out_ready=1 -> results 14 and 2 at cycles 8 and 9 after issue, with tags preserved.
- REQ-035 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIV 7/-2 -> 0xFFFFFFFD; REM 7/-2 -> 1.
- REQ-036 DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0; out_dz/out_ovf set when the macro is defined.
- REQ-037 Issue 10 ops back-to-back with out_ready held low for 3 cycles at first result -> in_ready low for those 3 cycles, no loss or reorder, result 1 held stable.
- REQ-038 Assert rst for 1 cycle with 4 ops in flight -> no out_valid for them; a new op issued after reset completes in 8 cycles.
